card_dealer: RTL and testbench
==============================

// Module: card_dealer
// PURPOSE
//  Upstream card source for the blackjack FSM: holds one 52-card deck, shuffles
//  it with an LFSR-driven Fisher-Yates pass, deals one card per request.
//  card_value drives the FSM's 4-bit mem input; hit/stay logic raises deal_req.
// PARAMETERS
//  LFSR_SEED   16'hACE1  reset seed of the 16-bit LFSR; 0 is replaced by 16'hACE1
//  FACE_VALUE  10        blackjack value reported for ranks 10..13 (J,Q,K)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  deal_req     in   1  request next card (level sampled each cycle)
//  shuffle_req  in   1  restore all 52 cards and reshuffle
//  card_value   out  4  blackjack value of dealt card, 1..10 (ace = 1)
//  card_rank    out  4  rank of dealt card, 1..13
//  card_valid   out  1  one-cycle pulse: card_value/card_rank valid
//  cards_left   out  6  cards remaining in deck, 0..52
//  deck_empty   out  1  cards_left == 0 while READY
//  busy         out  1  high in FILL/SHUFFLE; requests ignored
// BEHAVIOUR
//  Reset: outputs 0, except busy=1. cards_left=0. LFSR loads seed. State -> FILL.
//  LFSR: x^16+x^14+x^13+x^11 Fibonacci, shifts every non-reset cycle.
//  Deck: 52 x 4-bit register array, deck[k] = rank.
//  FSM states FILL, SHUFFLE, READY:
//   FILL: 52 cycles, deck[k] = (k mod 13)+1, k = 0..51.
//     Then cards_left=52, i=51, -> SHUFFLE.
//   SHUFFLE: each cycle j = lfsr[5:0].
//     j <= i: swap deck[i]/deck[j], i=i-1. j > i: retry next cycle.
//     Leave after the i=1 swap -> READY, busy=0 the same cycle.
//   READY: deal ptr p starts at 0.
//     deal_req && !deck_empty: next cycle card_valid=1,
//       card_rank=deck[p], card_value=(rank>=10)?FACE_VALUE:rank.
//       p+1, cards_left-1. Back-to-back: one card per cycle while held.
//     deal_req && deck_empty: no pulse, state unchanged.
//     shuffle_req: -> FILL, busy=1 next cycle, no card dealt. Wins over deal_req.
//  card_value/card_rank hold the last dealt card until the next deal or reset.
//  Requests while busy are dropped, not queued.
//  rst mid-FILL or mid-SHUFFLE: restart at FILL with LFSR reseeded.
//  Same seed + same cycle-exact stimulus gives an identical card sequence.
// TESTING
//  rst 1 cycle, idle -> busy=1 >= 52+51 cycles, then busy=0, cards_left=52, deck_empty=0.
//  52 deal_req pulses -> 52 card_valid pulses.
//    Ranks 1..13 four each; values 1..9 four each, value 10 sixteen times;
//    cards_left steps 52->0.
//  53rd deal_req -> no card_valid; deck_empty=1; card_value holds 52nd card.
//  deal_req and shuffle_req together in READY -> no card_valid; busy=1;
//    after shuffle, cards_left=52.
//  rst asserted mid-SHUFFLE -> re-run gives the same sequence as a clean reset with the same seed.
//  LFSR_SEED=0 -> sequence identical to LFSR_SEED=16'hACE1.

Source files
------------

// File: rtl/card_dealer_if.sv
// Request/response bundle between the blackjack FSM side (master) and the
// card dealer (slave). The master raises requests and the dealer returns cards.
interface card_dealer_if;
  logic       deal_req;
  logic       shuffle_req;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic       card_valid;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       busy;

  modport master (
    output deal_req, shuffle_req,
    input  card_value, card_rank, card_valid, cards_left, deck_empty, busy
  );

  modport slave (
    input  deal_req, shuffle_req,
    output card_value, card_rank, card_valid, cards_left, deck_empty, busy
  );
endinterface

// File: rtl/card_dealer.sv
// Card dealer: holds one 52-card deck. It refills the deck in rank order and
// shuffles it in place with an LFSR-driven Fisher-Yates pass. It then deals
// one card per request. The same seed and the same cycle-exact stimulus
// always reproduce the same card sequence.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [3:0]  FACE_VALUE = 4'd10
) (
  input  logic         clk,
  input  logic         rst,
  card_dealer_if.slave bus
);

  localparam logic [1:0]  ST_FILL    = 2'd0;
  localparam logic [1:0]  ST_SHUFFLE = 2'd1;
  localparam logic [1:0]  ST_READY   = 2'd2;
  localparam logic [5:0]  LAST_IDX   = 6'd51;
  localparam logic [5:0]  DECK_SIZE  = 6'd52;
  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  // Jacks, queens and kings all score as a face card.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      return FACE_VALUE;
    end else begin
      return rank;
    end
  endfunction

  logic [1:0]  state_r;
  logic [15:0] lfsr_r;
  // Shared index: fill position k in FILL, Fisher-Yates i in SHUFFLE,
  // deal pointer p in READY. The phases never overlap.
  logic [5:0]  idx_r;
  logic [3:0]  fill_rank_r;   // (k mod 13) + 1 tracked incrementally
  logic [3:0]  deck_r [52];

  logic [3:0]  card_value_r;
  logic [3:0]  card_rank_r;
  logic        card_valid_r;
  logic [5:0]  cards_left_r;
  logic        deck_empty_r;
  logic        busy_r;

  logic        lfsr_fb_s;
  logic [5:0]  swap_j_s;
  logic        swap_ok_s;
  logic        deal_go_s;
  logic [3:0]  deal_rank_s;

  // LFSR feedback, shuffle swap candidate and deal qualification.
  always_comb begin
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    swap_j_s  = lfsr_r[5:0];
    swap_ok_s = (state_r == ST_SHUFFLE) && (swap_j_s <= idx_r);
    deal_go_s = (state_r == ST_READY) && bus.deal_req && !bus.shuffle_req && !deck_empty_r;
    if (idx_r <= LAST_IDX) begin
      deal_rank_s = deck_r[idx_r];
    end else begin
      deal_rank_s = 4'd0;
    end
  end

  // Control FSM, LFSR stepping and registered card outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_FILL;
      lfsr_r       <= SEED_EFF;
      idx_r        <= 6'd0;
      fill_rank_r  <= 4'd1;
      card_value_r <= 4'd0;
      card_rank_r  <= 4'd0;
      card_valid_r <= 1'b0;
      cards_left_r <= 6'd0;
      deck_empty_r <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      lfsr_r       <= {lfsr_r[14:0], lfsr_fb_s};
      card_valid_r <= 1'b0;
      case (state_r)
        ST_FILL: begin
          if (idx_r == LAST_IDX) begin
            state_r      <= ST_SHUFFLE;
            cards_left_r <= DECK_SIZE;
            fill_rank_r  <= 4'd1;
          end else begin
            idx_r       <= idx_r + 6'd1;
            fill_rank_r <= (fill_rank_r == 4'd13) ? 4'd1 : (fill_rank_r + 4'd1);
          end
        end
        ST_SHUFFLE: begin
          // An out-of-range j just retries with the next LFSR value.
          if (swap_ok_s) begin
            if (idx_r == 6'd1) begin
              state_r      <= ST_READY;
              busy_r       <= 1'b0;
              idx_r        <= 6'd0;
              deck_empty_r <= 1'b0;
            end else begin
              idx_r <= idx_r - 6'd1;
            end
          end
        end
        ST_READY: begin
          // A shuffle request takes priority over a simultaneous deal.
          if (bus.shuffle_req) begin
            state_r      <= ST_FILL;
            busy_r       <= 1'b1;
            idx_r        <= 6'd0;
            fill_rank_r  <= 4'd1;
            cards_left_r <= 6'd0;
            deck_empty_r <= 1'b0;
          end else if (deal_go_s) begin
            card_valid_r <= 1'b1;
            card_rank_r  <= deal_rank_s;
            card_value_r <= rank_to_value(deal_rank_s);
            idx_r        <= idx_r + 6'd1;
            cards_left_r <= cards_left_r - 6'd1;
            deck_empty_r <= (cards_left_r == 6'd1);
          end
        end
        default: begin
          state_r      <= ST_FILL;
          busy_r       <= 1'b1;
          idx_r        <= 6'd0;
          fill_rank_r  <= 4'd1;
          cards_left_r <= 6'd0;
          deck_empty_r <= 1'b0;
        end
      endcase
    end
  end

  // Deck storage: sequential rank fill, then in-place Fisher-Yates swaps.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_FILL)) begin
      deck_r[idx_r] <= fill_rank_r;
    end else if (!rst && swap_ok_s) begin
      deck_r[idx_r]    <= deck_r[swap_j_s];
      deck_r[swap_j_s] <= deck_r[idx_r];
    end
  end

  assign bus.card_value = card_value_r;
  assign bus.card_rank  = card_rank_r;
  assign bus.card_valid = card_valid_r;
  assign bus.cards_left = cards_left_r;
  assign bus.deck_empty = deck_empty_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer. The expected deck order comes from a
// behavioural Fisher-Yates model that is driven by the LFSR polynomial.
module tb_card_dealer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_dealer_if bus();
  card_dealer_if bus_z();

  assign bus_z.deal_req    = bus.deal_req;
  assign bus_z.shuffle_req = bus.shuffle_req;

  card_dealer #(.LFSR_SEED(16'hACE1), .FACE_VALUE(4'd10)) dut   (.clk(clk), .rst(rst), .bus(bus));
  card_dealer #(.LFSR_SEED(16'h0000), .FACE_VALUE(4'd10)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_deck [52];
  int shuffle_cycles;
  int rank_cnt [16];
  int val_cnt  [16];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [3:0] exp_value(input logic [3:0] r);
    return (r > 4'd9) ? 4'd10 : r;
  endfunction

  // Reference deck: 52 fill cycles, then one LFSR draw per shuffle cycle.
  task automatic build_model(input logic [15:0] seed);
    logic [15:0] s;
    logic [3:0]  t;
    int i;
    int j;
    s = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < 52; k++) begin
      exp_deck[k] = 4'((k % 13) + 1);
      s = lfsr_next(s);
    end
    i = 51;
    shuffle_cycles = 0;
    while (i >= 1) begin
      j = int'(s[5:0]);
      if (j <= i) begin
        t = exp_deck[i]; exp_deck[i] = exp_deck[j]; exp_deck[j] = t;
        i--;
      end
      s = lfsr_next(s);
      shuffle_cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.deal_req = 1'b0; bus.shuffle_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 16; k++) begin rank_cnt[k] = 0; val_cnt[k] = 0; end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.card_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.card_valid); else passed++;
    checks++; if (bus.card_value !== 4'd0) $display("FAIL reset_value: got %0d want 0", bus.card_value); else passed++;
    checks++; if (bus.card_rank !== 4'd0) $display("FAIL reset_rank: got %0d want 0", bus.card_rank); else passed++;
    checks++; if (bus.cards_left !== 6'd0) $display("FAIL reset_cards_left: got %0d want 0", bus.cards_left); else passed++;
    checks++; if (bus.deck_empty !== 1'b0) $display("FAIL reset_deck_empty: got %b want 0", bus.deck_empty); else passed++;
    wait_ready(n);
    checks++; if (n != 52 + shuffle_cycles) $display("FAIL busy_cycles: got %0d want %0d", n, 52 + shuffle_cycles); else passed++;
    checks++; if (n < 103) $display("FAIL busy_min: got %0d want >= 103", n); else passed++;
    checks++; if (bus.cards_left !== 6'd52) $display("FAIL ready_cards_left: got %0d want 52", bus.cards_left); else passed++;
    checks++; if (bus.deck_empty !== 1'b0) $display("FAIL ready_deck_empty: got %b want 0", bus.deck_empty); else passed++;
  endtask

  // Random request pattern (gaps and back-to-back runs) through the whole deck.
  task automatic test_deal_random();
    int p = 0;
    int cyc = 0;
    logic req;
    logic [3:0] held;
    clear_hist();
    while (p < 52 && cyc < 400) begin
      req = 1'($urandom_range(0, 1));
      bus.deal_req = req;
      @(negedge clk);
      cyc++;
      if (req) begin
        checks++; if (bus.card_valid !== 1'b1) $display("FAIL deal_valid[%0d]: got %b want 1", p, bus.card_valid); else passed++;
        checks++; if (bus.card_rank !== exp_deck[p]) $display("FAIL deal_rank[%0d]: got %0d want %0d", p, bus.card_rank, exp_deck[p]); else passed++;
        checks++; if (bus.card_value !== exp_value(exp_deck[p])) $display("FAIL deal_value[%0d]: got %0d want %0d", p, bus.card_value, exp_value(exp_deck[p])); else passed++;
        checks++; if (bus.cards_left !== 6'(51 - p)) $display("FAIL deal_cards_left[%0d]: got %0d want %0d", p, bus.cards_left, 51 - p); else passed++;
        checks++; if (bus.deck_empty !== (p == 51)) $display("FAIL deal_deck_empty[%0d]: got %b want %b", p, bus.deck_empty, (p == 51)); else passed++;
        rank_cnt[bus.card_rank]++;
        val_cnt[bus.card_value]++;
        p++;
      end else begin
        held = (p == 0) ? 4'd0 : exp_deck[p - 1];
        checks++; if (bus.card_valid !== 1'b0) $display("FAIL gap_valid[%0d]: got %b want 0", p, bus.card_valid); else passed++;
        checks++; if (bus.card_rank !== held) $display("FAIL gap_hold_rank[%0d]: got %0d want %0d", p, bus.card_rank, held); else passed++;
      end
    end
    bus.deal_req = 1'b0;
    checks++; if (p != 52) $display("FAIL deal_timeout: got %0d cards want 52", p); else passed++;
    for (int r = 1; r <= 13; r++) begin
      checks++; if (rank_cnt[r] != 4) $display("FAIL rank_count[%0d]: got %0d want 4", r, rank_cnt[r]); else passed++;
    end
    for (int v = 1; v <= 10; v++) begin
      checks++; if (val_cnt[v] != ((v == 10) ? 16 : 4)) $display("FAIL value_count[%0d]: got %0d want %0d", v, val_cnt[v], (v == 10) ? 16 : 4); else passed++;
    end
  endtask

  task automatic test_empty();
    bus.deal_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.card_valid !== 1'b0) $display("FAIL empty_valid: got %b want 0", bus.card_valid); else passed++;
      checks++; if (bus.deck_empty !== 1'b1) $display("FAIL empty_flag: got %b want 1", bus.deck_empty); else passed++;
      checks++; if (bus.cards_left !== 6'd0) $display("FAIL empty_cards_left: got %0d want 0", bus.cards_left); else passed++;
      checks++; if (bus.card_rank !== exp_deck[51]) $display("FAIL empty_hold_rank: got %0d want %0d", bus.card_rank, exp_deck[51]); else passed++;
      checks++; if (bus.card_value !== exp_value(exp_deck[51])) $display("FAIL empty_hold_value: got %0d want %0d", bus.card_value, exp_value(exp_deck[51])); else passed++;
    end
    bus.deal_req = 1'b0;
  endtask

  task automatic test_shuffle_priority();
    int n = 0;
    int p;
    bus.deal_req = 1'b1; bus.shuffle_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.card_valid !== 1'b0) $display("FAIL prio_valid: got %b want 0", bus.card_valid); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL prio_busy: got %b want 1", bus.busy); else passed++;
    // Requests while busy are dropped.
    while (bus.busy === 1'b1 && n < 4000) begin
      bus.deal_req    = 1'($urandom_range(0, 1));
      bus.shuffle_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      checks++; if (bus.card_valid !== 1'b0) $display("FAIL busy_drop_valid[%0d]: got %b want 0", n, bus.card_valid); else passed++;
    end
    bus.deal_req = 1'b0; bus.shuffle_req = 1'b0;
    checks++; if (n >= 4000) $display("FAIL reshuffle_timeout: got %0d cycles want < 4000", n); else passed++;
    checks++; if (bus.cards_left !== 6'd52) $display("FAIL reshuffle_cards_left: got %0d want 52", bus.cards_left); else passed++;
    checks++; if (bus.deck_empty !== 1'b0) $display("FAIL reshuffle_deck_empty: got %b want 0", bus.deck_empty); else passed++;
    checks++; if (bus.card_rank !== exp_deck[51]) $display("FAIL reshuffle_hold_rank: got %0d want %0d", bus.card_rank, exp_deck[51]); else passed++;
    clear_hist();
    bus.deal_req = 1'b1;
    for (p = 0; p < 52; p++) begin
      @(negedge clk);
      checks++; if (bus.card_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", p, bus.card_valid); else passed++;
      checks++; if (bus.cards_left !== 6'(51 - p)) $display("FAIL b2b_cards_left[%0d]: got %0d want %0d", p, bus.cards_left, 51 - p); else passed++;
      rank_cnt[bus.card_rank]++;
      val_cnt[bus.card_value]++;
    end
    bus.deal_req = 1'b0;
    for (int r = 1; r <= 13; r++) begin
      checks++; if (rank_cnt[r] != 4) $display("FAIL b2b_rank_count[%0d]: got %0d want 4", r, rank_cnt[r]); else passed++;
    end
    checks++; if (val_cnt[10] != 16) $display("FAIL b2b_value10_count: got %0d want 16", val_cnt[10]); else passed++;
  endtask

  task automatic test_rst_mid_shuffle();
    int n;
    do_reset();
    repeat (60) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_shuffle_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.cards_left !== 6'd52) $display("FAIL mid_shuffle_cards_left: got %0d want 52", bus.cards_left); else passed++;
    do_reset();
    checks++; if (bus.cards_left !== 6'd0) $display("FAIL rerst_cards_left: got %0d want 0", bus.cards_left); else passed++;
    wait_ready(n);
    checks++; if (n != 52 + shuffle_cycles) $display("FAIL rerst_busy_cycles: got %0d want %0d", n, 52 + shuffle_cycles); else passed++;
    bus.deal_req = 1'b1;
    for (int p = 0; p < 52; p++) begin
      @(negedge clk);
      checks++; if (bus.card_rank !== exp_deck[p] || bus.card_valid !== 1'b1) $display("FAIL rerst_rank[%0d]: got %0d valid %b want %0d", p, bus.card_rank, bus.card_valid, exp_deck[p]); else passed++;
    end
    bus.deal_req = 1'b0;
  endtask

  task automatic test_seed_zero();
    int n;
    build_model(16'h0000);
    do_reset();
    wait_ready(n);
    checks++; if (bus_z.busy !== 1'b0 || bus_z.cards_left !== 6'd52) $display("FAIL zero_ready: got busy %b left %0d want 0/52", bus_z.busy, bus_z.cards_left); else passed++;
    bus.deal_req = 1'b1;
    for (int p = 0; p < 52; p++) begin
      @(negedge clk);
      checks++; if (bus_z.card_rank !== exp_deck[p] || bus_z.card_valid !== 1'b1) $display("FAIL zero_rank[%0d]: got %0d valid %b want %0d", p, bus_z.card_rank, bus_z.card_valid, exp_deck[p]); else passed++;
      checks++; if (bus_z.card_value !== exp_value(exp_deck[p])) $display("FAIL zero_value[%0d]: got %0d want %0d", p, bus_z.card_value, exp_value(exp_deck[p])); else passed++;
    end
    bus.deal_req = 1'b0;
  endtask

  initial begin
    bus.deal_req = 1'b0;
    bus.shuffle_req = 1'b0;
    build_model(16'hACE1);
    test_reset();
    test_deal_random();
    test_empty();
    test_shuffle_priority();
    test_rst_mid_shuffle();
    test_seed_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
